// File: rtl/branch_predictor.sv
// Fetch-side dynamic branch predictor: direct-mapped table of 2-bit direction
// counters plus BTB targets, looked up by the IF PC and trained from EX.
module branch_predictor #(
  parameter int         INDEX_BITS = 5,
  parameter logic [1:0] CTR_INIT   = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_br_valid,
  input  logic        ex_advance,
  input  logic [31:0] ex_pc,
  input  logic        ex_br_en,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        mispredict,
  output logic [31:0] br_count,
  output logic [31:0] mispred_count
);

  localparam int ENTRIES  = 1 << INDEX_BITS;
  localparam int TAG_BITS = 32 - INDEX_BITS - 2;

  function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    if (taken) begin
      nxt = (ctr == 2'b11) ? ctr : ctr + 2'b01;
    end else begin
      nxt = (ctr == 2'b00) ? ctr : ctr - 2'b01;
    end
    return nxt;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic                  valid_r  [ENTRIES];
  logic [TAG_BITS-1:0]   tag_r    [ENTRIES];
  logic [31:0]           target_r [ENTRIES];
  logic [1:0]            ctr_r    [ENTRIES];
  logic [31:0]           br_count_r;
  logic [31:0]           mispred_count_r;

  logic [INDEX_BITS-1:0] if_idx_s;
  logic [TAG_BITS-1:0]   if_tag_s;
  logic [INDEX_BITS-1:0] ex_idx_s;
  logic [TAG_BITS-1:0]   ex_tag_s;
  logic                  ex_hit_s;
  logic                  upd_s;
  logic                  mispredict_s;
  logic                  unused_s;

  assign if_idx_s = if_pc[INDEX_BITS+1:2];
  assign if_tag_s = if_pc[31:INDEX_BITS+2];
  assign ex_idx_s = ex_pc[INDEX_BITS+1:2];
  assign ex_tag_s = ex_pc[31:INDEX_BITS+2];
  assign ex_hit_s = valid_r[ex_idx_s] && (tag_r[ex_idx_s] == ex_tag_s);
  assign upd_s    = ex_br_valid & ex_advance;
  assign unused_s = ^{if_pc[1:0], ex_pc[1:0]};

  // Lookup reads the table as it stood before this cycle's training write.
  always_comb begin
    pred_hit    = 1'b0;
    pred_taken  = 1'b0;
    pred_target = 32'd0;
    if (valid_r[if_idx_s] && (tag_r[if_idx_s] == if_tag_s)) begin
      pred_hit    = 1'b1;
      pred_taken  = ctr_r[if_idx_s][1];
      pred_target = target_r[if_idx_s];
    end else begin
      pred_hit    = 1'b0;
    end
  end

  // Mispredict compares the carried prediction with the resolved outcome.
  always_comb begin
    mispredict_s = 1'b0;
    if (ex_br_valid) begin
      mispredict_s = (ex_pred_taken != ex_br_en) |
                     (ex_br_en & ex_pred_taken & (ex_pred_target != ex_target));
    end else begin
      mispredict_s = 1'b0;
    end
  end

  assign mispredict = mispredict_s;

  // Table training; not-taken misses never allocate, reset drops a coincident update.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_r[i]  <= 1'b0;
        tag_r[i]    <= '0;
        target_r[i] <= 32'd0;
        ctr_r[i]    <= CTR_INIT;
      end
    end else if (upd_s) begin
      if (ex_hit_s) begin
        ctr_r[ex_idx_s] <= ctr_step(ctr_r[ex_idx_s], ex_br_en);
        if (ex_br_en) begin
          target_r[ex_idx_s] <= ex_target;
        end
      end else if (ex_br_en) begin
        valid_r[ex_idx_s]  <= 1'b1;
        tag_r[ex_idx_s]    <= ex_tag_s;
        target_r[ex_idx_s] <= ex_target;
        ctr_r[ex_idx_s]    <= 2'b10;
      end
    end
  end

  // Saturating branch and mispredict statistics, stepped once per retiring branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      br_count_r      <= 32'd0;
      mispred_count_r <= 32'd0;
    end else if (upd_s) begin
      br_count_r <= sat_inc32(br_count_r);
      if (mispredict_s) begin
        mispred_count_r <= sat_inc32(mispred_count_r);
      end
    end
  end

  assign br_count      = br_count_r;
  assign mispred_count = mispred_count_r;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed vector table, a reset
// collision sequence, then randomized traffic against a behavioural model.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_br_valid;
  logic        ex_advance;
  logic [31:0] ex_pc;
  logic        ex_br_en;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        mispredict;
  logic [31:0] br_count;
  logic [31:0] mispred_count;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk(clk), .rst(rst), .if_pc(if_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_br_valid(ex_br_valid), .ex_advance(ex_advance), .ex_pc(ex_pc),
    .ex_br_en(ex_br_en), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target), .mispredict(mispredict),
    .br_count(br_count), .mispred_count(mispred_count)
  );

  typedef struct {
    bit          chk;
    bit          rst;
    logic [31:0] if_pc;
    bit          v;
    bit          adv;
    logic [31:0] ex_pc;
    bit          en;
    logic [31:0] tgt;
    bit          pt;
    logic [31:0] ptgt;
    bit          e_hit;
    bit          e_taken;
    logic [31:0] e_tgt;
    bit          e_misp;
    int unsigned e_br;
    int unsigned e_mp;
  } vec_t;

  int n_cmp = 0;
  int n_fail = 0;

  // Behavioural model: 32 slots keyed by the full word address.
  bit          m_valid [32];
  logic [29:0] m_key   [32];
  logic [31:0] m_tgt   [32];
  int          m_ctr   [32];
  longint      m_br, m_mp;

  function automatic vec_t mk(bit chk, bit r, logic [31:0] ipc, bit v, bit adv,
                              logic [31:0] epc, bit en, logic [31:0] tgt, bit pt,
                              logic [31:0] ptgt, bit eh, bit et, logic [31:0] etg,
                              bit em, int unsigned eb, int unsigned emp);
    vec_t t;
    t.chk = chk; t.rst = r; t.if_pc = ipc; t.v = v; t.adv = adv; t.ex_pc = epc;
    t.en = en; t.tgt = tgt; t.pt = pt; t.ptgt = ptgt; t.e_hit = eh; t.e_taken = et;
    t.e_tgt = etg; t.e_misp = em; t.e_br = eb; t.e_mp = emp;
    return t;
  endfunction

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int slot(input logic [31:0] pc);
    return int'(pc[6:2]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_valid[i] = 1'b0; m_key[i] = 30'd0; m_tgt[i] = 32'd0; m_ctr[i] = 1;
    end
    m_br = 0; m_mp = 0;
  endtask

  function automatic bit model_misp();
    if (!ex_br_valid) return 1'b0;
    if (ex_pred_taken != ex_br_en) return 1'b1;
    return ex_br_en && ex_pred_taken && (ex_pred_target != ex_target);
  endfunction

  // Applies the inputs present at the active edge to the model.
  task automatic model_edge();
    int s;
    if (rst) begin
      model_reset();
    end else if (ex_br_valid && ex_advance) begin
      s = slot(ex_pc);
      if (model_misp() && m_mp < 64'hFFFF_FFFF) m_mp++;
      if (m_br < 64'hFFFF_FFFF) m_br++;
      if (m_valid[s] && m_key[s] == ex_pc[31:2]) begin
        m_ctr[s] = ex_br_en ? ((m_ctr[s] == 3) ? 3 : m_ctr[s] + 1)
                            : ((m_ctr[s] == 0) ? 0 : m_ctr[s] - 1);
        if (ex_br_en) m_tgt[s] = ex_target;
      end else if (ex_br_en) begin
        m_valid[s] = 1'b1; m_key[s] = ex_pc[31:2]; m_tgt[s] = ex_target; m_ctr[s] = 2;
      end
    end
  endtask

  task automatic apply(input vec_t t, input string tag);
    rst = t.rst; if_pc = t.if_pc; ex_br_valid = t.v; ex_advance = t.adv;
    ex_pc = t.ex_pc; ex_br_en = t.en; ex_target = t.tgt;
    ex_pred_taken = t.pt; ex_pred_target = t.ptgt;
    @(negedge clk);
    if (t.chk) begin
      check1({tag, ".pred_hit"}, {31'd0, pred_hit}, {31'd0, t.e_hit});
      check1({tag, ".pred_taken"}, {31'd0, pred_taken}, {31'd0, t.e_taken});
      check1({tag, ".pred_target"}, pred_target, t.e_tgt);
      check1({tag, ".mispredict"}, {31'd0, mispredict}, {31'd0, t.e_misp});
      check1({tag, ".br_count"}, br_count, t.e_br);
      check1({tag, ".mispred_count"}, mispred_count, t.e_mp);
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  vec_t tbl[$];
  vec_t seq[$];

  initial begin
    logic [31:0] pool [4];
    int          s;
    bit          mh;
    vec_t        r;

    rst = 1'b1; if_pc = 32'd0; ex_br_valid = 1'b0; ex_advance = 1'b0; ex_pc = 32'd0;
    ex_br_en = 1'b0; ex_target = 32'd0; ex_pred_taken = 1'b0; ex_pred_target = 32'd0;
    model_reset();
    @(posedge clk);
    #1;

    tbl.push_back(mk(0,1,32'h0,   0,0,32'h0,0,32'h0,0,32'h0,   0,0,32'h0,0,0,0));
    tbl.push_back(mk(1,0,32'h60,  0,0,32'h0,0,32'h0,0,32'h0,   0,0,32'h0,0,0,0));
    tbl.push_back(mk(1,0,32'h100, 1,1,32'h100,1,32'h80,0,32'h0, 0,0,32'h0,1,0,0));
    tbl.push_back(mk(1,0,32'h100, 0,0,32'h0,0,32'h0,0,32'h0,   1,1,32'h80,0,1,1));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(1,0,32'h100, 1,1,32'h100,1,32'h80,1,32'h80, 1,1,32'h80,0,1+k,1));
    tbl.push_back(mk(1,0,32'h100, 1,1,32'h100,0,32'h80,1,32'h80, 1,1,32'h80,1,5,1));
    tbl.push_back(mk(1,0,32'h100, 1,1,32'h100,0,32'h80,1,32'h80, 1,1,32'h80,1,6,2));
    tbl.push_back(mk(1,0,32'h100, 1,1,32'h100,0,32'h80,0,32'h80, 1,0,32'h80,0,7,3));
    tbl.push_back(mk(1,0,32'h100, 0,1,32'h100,1,32'h80,0,32'h0, 1,0,32'h80,0,8,3));
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(1,0,32'h101, 1,0,32'h102,1,32'h80,0,32'h0, 1,0,32'h80,1,8,3));
    tbl.push_back(mk(1,0,32'h101, 1,1,32'h102,1,32'h80,0,32'h0, 1,0,32'h80,1,8,3));
    tbl.push_back(mk(1,0,32'h100, 0,0,32'h0,0,32'h0,0,32'h0,   1,0,32'h80,0,9,4));
    tbl.push_back(mk(1,0,32'h180, 1,1,32'h180,1,32'h300,0,32'h0, 0,0,32'h0,1,9,4));
    tbl.push_back(mk(1,0,32'h100, 0,0,32'h0,0,32'h0,1,32'h0,   0,0,32'h0,0,10,5));
    tbl.push_back(mk(1,0,32'h180, 1,1,32'h180,1,32'h200,1,32'h80, 1,1,32'h300,1,10,5));
    tbl.push_back(mk(1,0,32'h183, 0,0,32'h0,0,32'h0,0,32'h0,   1,1,32'h200,0,11,6));
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Reset colliding with a taken update: the update must be dropped.
    seq.push_back(mk(1,1,32'h180, 1,1,32'h60,1,32'h44,0,32'h0, 1,1,32'h200,1,11,6));
    seq.push_back(mk(1,0,32'h180, 0,0,32'h0,0,32'h0,0,32'h0,   0,0,32'h0,0,0,0));
    seq.push_back(mk(1,0,32'h60,  0,0,32'h0,0,32'h0,0,32'h0,   0,0,32'h0,0,0,0));
    for (int i = 0; i < seq.size(); i++) apply(seq[i], $sformatf("rstcol%0d", i));

    pool[0] = 32'h80; pool[1] = 32'h200; pool[2] = 32'h1234; pool[3] = 32'hFFFF_FFFC;
    for (int n = 0; n < 600; n++) begin
      r.chk = 1'b0;
      r.rst = ($urandom_range(0, 99) == 0);
      r.if_pc = ($urandom_range(0, 3) << 7) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      r.v = $urandom_range(0, 3) != 0;
      r.adv = $urandom_range(0, 2) != 0;
      r.ex_pc = ($urandom_range(0, 3) << 7) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      r.en = $urandom_range(0, 1);
      r.tgt = pool[$urandom_range(0, 3)];
      s = slot(r.ex_pc);
      mh = m_valid[s] && (m_key[s] == r.ex_pc[31:2]);
      if ($urandom_range(0, 1) == 1) begin
        r.pt = mh && (m_ctr[s] >= 2);
        r.ptgt = mh ? m_tgt[s] : 32'd0;
      end else begin
        r.pt = $urandom_range(0, 1);
        r.ptgt = pool[$urandom_range(0, 3)];
      end
      rst = r.rst; if_pc = r.if_pc; ex_br_valid = r.v; ex_advance = r.adv;
      ex_pc = r.ex_pc; ex_br_en = r.en; ex_target = r.tgt;
      ex_pred_taken = r.pt; ex_pred_target = r.ptgt;
      @(negedge clk);
      s = slot(if_pc);
      mh = m_valid[s] && (m_key[s] == if_pc[31:2]);
      check1("rnd.pred_hit", {31'd0, pred_hit}, {31'd0, mh});
      check1("rnd.pred_taken", {31'd0, pred_taken}, {31'd0, mh && (m_ctr[s] >= 2)});
      check1("rnd.pred_target", pred_target, mh ? m_tgt[s] : 32'd0);
      check1("rnd.mispredict", {31'd0, mispredict}, {31'd0, model_misp()});
      check1("rnd.br_count", br_count, m_br[31:0]);
      check1("rnd.mispred_count", mispred_count, m_mp[31:0]);
      @(posedge clk);
      model_edge();
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
